bus_cycle_decoder: RTL and testbench

BUS_CYCLE_DECODER -- requirements
Module: bus_cycle_decoder

---
 rtl/bus_cycle_decoder_pkg.sv | 42 ++++
 rtl/bus_cycle_decoder_if.sv | 35 +++
 rtl/bus_cycle_decoder_region_decode.sv | 22 ++
 rtl/bus_cycle_decoder.sv | 132 +++++++++++++
 tb/tb_bus_cycle_decoder.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bus_cycle_decoder_pkg.sv
// Shared types and constants for the bus cycle decoder.
//   state_t    : cycle FSM states
//   region_t   : decoded memory region of the latched address
//   bus_out_t  : registered output bundle (chip selects, enables, terminations)
//   REGION_MASK/PROM_BASE/SRAM_BASE : 512 KiB windows selected by ADDR[23:19]
//   DEFAULT_*  : default wait states and bus-error timeout
package bus_cycle_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        REGION_PROM,
        REGION_SRAM,
        REGION_NONE
    } region_t;

    typedef struct packed {
        logic sramcs0;
        logic sramcs1;
        logic promcs0;
        logic promcs1;
        logic oe;
        logic weu;
        logic wel;
        logic dtack;
        logic berr;
    } bus_out_t;

    localparam logic [23:0] REGION_MASK = 24'hF8_0000;
    localparam logic [23:0] PROM_BASE   = 24'h00_0000;
    localparam logic [23:0] SRAM_BASE   = 24'h08_0000;

    localparam int DEFAULT_PROM_WAIT    = 2;
    localparam int DEFAULT_SRAM_WAIT    = 0;
    localparam int DEFAULT_BERR_TIMEOUT = 64;

endpackage

// File: rtl/bus_cycle_decoder_if.sv
// CPU-side bus bundle of the bus cycle decoder.
//   CPU -> decoder : AS_IN, UDS_IN, LDS_IN, RW_IN, ADDR_IN[23:0], STALL_IN
//   decoder -> mem : SRAMCS0/1, PROMCS0/1 (0 = upper byte, 1 = lower byte), OE, WEU, WEL
//   decoder -> CPU : DTACK, BERR
// master: the CPU / bus-control side. slave: the decoder.
interface bus_cycle_decoder_if;

    logic        AS_IN;
    logic        UDS_IN;
    logic        LDS_IN;
    logic        RW_IN;
    logic [23:0] ADDR_IN;
    logic        STALL_IN;

    logic        SRAMCS0;
    logic        SRAMCS1;
    logic        PROMCS0;
    logic        PROMCS1;
    logic        OE;
    logic        WEU;
    logic        WEL;
    logic        DTACK;
    logic        BERR;

    modport master (
        output AS_IN, UDS_IN, LDS_IN, RW_IN, ADDR_IN, STALL_IN,
        input  SRAMCS0, SRAMCS1, PROMCS0, PROMCS1, OE, WEU, WEL, DTACK, BERR
    );

    modport slave (
        input  AS_IN, UDS_IN, LDS_IN, RW_IN, ADDR_IN, STALL_IN,
        output SRAMCS0, SRAMCS1, PROMCS0, PROMCS1, OE, WEU, WEL, DTACK, BERR
    );

endinterface

// File: rtl/bus_cycle_decoder_region_decode.sv
// Combinational address decoder.
//   addr   in  24  CPU address
//   region out     PROM for 0x000000-0x07FFFF, SRAM for 0x080000-0x0FFFFF, else NONE
module region_decode
    import bus_cycle_decoder_pkg::*;
(
    input  logic [23:0] addr,
    output region_t     region
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through it leaves the value unassigned (which would infer a latch).
    always_comb begin
        region = REGION_NONE;
        if ((addr & REGION_MASK) == PROM_BASE) begin
            region = REGION_PROM;
        end else if ((addr & REGION_MASK) == SRAM_BASE) begin
            region = REGION_SRAM;
        end
    end

endmodule

// File: rtl/bus_cycle_decoder.sv
// 68000-style bus cycle decoder: chip selects, output/write enables and
// DTACK/BERR generation with per-region wait states.
//   CPUCLK_IN in   sole clock, rising edge
//   RESET_IN  in   asynchronous active-high reset
//   bus       slave modport of bus_cycle_decoder_if (strobes, address, stall,
//             chip selects, enables, cycle terminations)
// Parameters: PROM_WAIT / SRAM_WAIT wait cycles before DTACK (0..255),
//             BERR_TIMEOUT cycles before BERR on unmapped accesses (1..255).
module bus_cycle_decoder
    import bus_cycle_decoder_pkg::*;
#(
    parameter int PROM_WAIT    = DEFAULT_PROM_WAIT,
    parameter int SRAM_WAIT    = DEFAULT_SRAM_WAIT,
    parameter int BERR_TIMEOUT = DEFAULT_BERR_TIMEOUT
)(
    input  logic              CPUCLK_IN,
    input  logic              RESET_IN,
    bus_cycle_decoder_if.slave bus
);

    localparam logic [7:0] PROM_LOAD = 8'(PROM_WAIT);
    localparam logic [7:0] SRAM_LOAD = 8'(SRAM_WAIT);
    localparam logic [7:0] BERR_LOAD = 8'(BERR_TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    region_t    region_q, region_next;
    logic       rw_q, rw_next;
    region_t    addr_region;
    bus_out_t   out_q, out_next;
    logic       active;

    region_decode u_region_decode (
        .addr   (bus.ADDR_IN),
        .region (addr_region)
    );

    // Next-state and counter logic. Region and direction are captured only
    // when leaving IDLE, so later address/RW changes are ignored.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        region_next = region_q;
        rw_next     = rw_q;
        unique case (state)
            ST_IDLE: begin
                if (bus.AS_IN) begin
                    state_next  = ST_WAIT;
                    region_next = addr_region;
                    rw_next     = bus.RW_IN;
                    unique case (addr_region)
                        REGION_PROM: cnt_next = PROM_LOAD;
                        REGION_SRAM: cnt_next = SRAM_LOAD;
                        default:     cnt_next = BERR_LOAD;
                    endcase
                end
            end
            ST_WAIT: begin
                if (!bus.AS_IN) begin
                    state_next = ST_IDLE;
                end else if (cnt == 8'd0) begin
                    // A stalled mapped access parks here with the count at 0.
                    if (region_q == REGION_NONE) begin
                        state_next = ST_FAULT;
                    end else if (!bus.STALL_IN) begin
                        state_next = ST_ACK;
                    end
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            ST_ACK, ST_FAULT: begin
                if (!bus.AS_IN) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered outputs. Strobe-driven selects appear one edge after the
    // address is latched (i.e. while WAIT/ACK persist) and fall at the edge
    // that samples AS low; byte lanes follow UDS/LDS as sampled each edge.
    always_comb begin
        out_next = '0;
        active   = (state != ST_IDLE) &&
                   ((state_next == ST_WAIT) || (state_next == ST_ACK));
        if (active) begin
            out_next.sramcs0 = (region_q == REGION_SRAM) && bus.UDS_IN;
            out_next.sramcs1 = (region_q == REGION_SRAM) && bus.LDS_IN;
            out_next.promcs0 = (region_q == REGION_PROM) && bus.UDS_IN;
            out_next.promcs1 = (region_q == REGION_PROM) && bus.LDS_IN;
            out_next.oe      = (region_q != REGION_NONE) && rw_q;
            // PROM writes terminate normally but drive no write enable.
            out_next.weu     = (region_q == REGION_SRAM) && !rw_q && bus.UDS_IN;
            out_next.wel     = (region_q == REGION_SRAM) && !rw_q && bus.LDS_IN;
        end
        out_next.dtack = (state_next == ST_ACK);
        out_next.berr  = (state_next == ST_FAULT);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    // NOTE: reset clears every register, outputs included, so the bus is quiet
    // the instant RESET_IN rises rather than at the next clock.
    always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state    <= ST_IDLE;
            cnt      <= 8'd0;
            region_q <= REGION_NONE;
            rw_q     <= 1'b0;
            out_q    <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            region_q <= region_next;
            rw_q     <= rw_next;
            out_q    <= out_next;
        end
    end

    assign bus.SRAMCS0 = out_q.sramcs0;
    assign bus.SRAMCS1 = out_q.sramcs1;
    assign bus.PROMCS0 = out_q.promcs0;
    assign bus.PROMCS1 = out_q.promcs1;
    assign bus.OE      = out_q.oe;
    assign bus.WEU     = out_q.weu;
    assign bus.WEL     = out_q.wel;
    assign bus.DTACK   = out_q.dtack;
    assign bus.BERR    = out_q.berr;

endmodule

// File: tb/tb_bus_cycle_decoder.sv
// Self-checking bench for bus_cycle_decoder. The driver describes each access
// as a whole (address, direction, AS hold length, stall and strobe patterns),
// derives the per-edge output levels from the memory map and wait-state rules,
// and queues them; a monitor compares the queued levels after each edge.
// Output vector order: {SRAMCS0,SRAMCS1,PROMCS0,PROMCS1,OE,WEU,WEL,DTACK,BERR}.
module tb_bus_cycle_decoder;
    import bus_cycle_decoder_pkg::*;

    localparam int PW = 2;
    localparam int SW = 0;
    localparam int BT = 64;

    typedef struct {
        int         cyc;
        logic [8:0] outs;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    bus_cycle_decoder_if bus();

    bus_cycle_decoder #(
        .PROM_WAIT    (PW),
        .SRAM_WAIT    (SW),
        .BERR_TIMEOUT (BT)
    ) dut (
        .CPUCLK_IN (clk),
        .RESET_IN  (rst),
        .bus       (bus)
    );

    function automatic logic [8:0] current_outs();
        return {bus.SRAMCS0, bus.SRAMCS1, bus.PROMCS0, bus.PROMCS1,
                bus.OE, bus.WEU, bus.WEL, bus.DTACK, bus.BERR};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %b required %b", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: compares each queued expectation after the edge it belongs to.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc < edge_cnt) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: expectation for edge %0d missed at edge %0d", e.name, e.cyc, edge_cnt);
                end else begin
                    check(e.name, current_outs(), e.outs);
                end
            end
        end
    end

    // Applies inputs for the next edge and queues the outputs expected after it.
    task automatic drive_edge(input logic as, input logic uds, input logic lds, input logic rw,
                              input logic [23:0] addr, input logic stall,
                              input logic [8:0] exp, input string name);
        bus.AS_IN    = as;
        bus.UDS_IN   = uds;
        bus.LDS_IN   = lds;
        bus.RW_IN    = rw;
        bus.ADDR_IN  = addr;
        bus.STALL_IN = stall;
        sb.push_back('{edge_cnt + 1, exp, name});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_edges(input int n);
        for (int i = 0; i < n; i++) begin
            drive_edge(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom),
                       1'($urandom), 9'd0, "idle");
        end
    endtask

    // One access: AS high for edges 0..hold-1, sampled low at edge hold.
    // stall_len >= 0 : STALL high at edges 0..stall_len-1, else random.
    // Reference rules: mapped DTACK rises at the first edge >= 1+WAIT that
    // samples STALL low; unmapped BERR rises at edge BERR_TIMEOUT; selects and
    // enables hold from edge 1 while AS stays high; everything drops at edge hold.
    task automatic do_access(input string name, input logic [23:0] addr, input logic rw,
                             input int hold, input int stall_len, input logic [1:0] strobes,
                             input bit rand_strobes, input bit scramble);
        bit prom   = (addr < 24'h08_0000);
        bit sram   = !prom && (addr < 24'h10_0000);
        bit mapped = prom || sram;
        int w      = prom ? PW : SW;
        bit acked  = 1'b0;
        for (int e = 0; e <= hold; e++) begin
            logic       as_e   = (e < hold);
            logic       s_e    = (stall_len >= 0) ? 1'(e < stall_len) : 1'($urandom_range(0, 2) == 0);
            logic       u_e    = rand_strobes ? 1'($urandom) : strobes[1];
            logic       l_e    = rand_strobes ? 1'($urandom) : strobes[0];
            logic [23:0] a_e   = (scramble && e > 0) ? 24'($urandom) : addr;
            logic       rw_e   = (scramble && e > 0) ? 1'($urandom) : rw;
            logic [8:0] exp    = 9'd0;
            if (as_e && e > 0) begin
                if (mapped && e >= w + 1 && !s_e) acked = 1'b1;
                exp = {sram && u_e, sram && l_e, prom && u_e, prom && l_e,
                       mapped && rw, sram && !rw && u_e, sram && !rw && l_e,
                       mapped && acked, !mapped && (e >= BT)};
            end
            drive_edge(as_e, u_e, l_e, rw_e, a_e, s_e, exp, name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.AS_IN    = 1'b0;
        bus.UDS_IN   = 1'b0;
        bus.LDS_IN   = 1'b0;
        bus.RW_IN    = 1'b1;
        bus.ADDR_IN  = 24'd0;
        bus.STALL_IN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", current_outs(), 9'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed accesses
        do_access("sram_read",      24'h08_0000, 1'b1, 4,      0, 2'b11, 0, 0);
        idle_edges(1);
        do_access("prom_read_lds",  24'h00_0400, 1'b1, 6,      0, 2'b01, 0, 0);
        do_access("unmapped_write", 24'h20_0000, 1'b0, BT + 3, 0, 2'b11, 0, 0);
        idle_edges(2);
        do_access("sram_wr_stall",  24'h0F_FFFE, 1'b0, 12,     6, 2'b10, 0, 0);
        do_access("prom_drop_cnt1", 24'h00_0010, 1'b1, 2,      0, 2'b11, 0, 0);
        do_access("prom_write",     24'h07_FFFE, 1'b0, 5,      0, 2'b11, 0, 0);
        do_access("sram_scramble",  24'h09_1234, 1'b1, 6,      0, 2'b11, 0, 1);
        do_access("unmapped_stall", 24'hF0_0000, 1'b1, BT + 2, 200, 2'b11, 0, 0);

        // Reset pulse during a PROM wait while the count is 1
        drive_edge(1'b1, 1'b1, 1'b1, 1'b1, 24'h00_0400, 1'b0, 9'd0, "rst_edge0");
        drive_edge(1'b1, 1'b1, 1'b1, 1'b1, 24'h00_0400, 1'b0, 9'b0011_1000_0, "rst_edge1");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("reset_async", current_outs(), 9'd0);
        drive_edge(1'b1, 1'b1, 1'b1, 1'b1, 24'h00_0400, 1'b0, 9'd0, "rst_held");
        @(negedge clk);
        rst = 1'b0;
        do_access("post_reset_prom", 24'h00_0400, 1'b1, 6, 0, 2'b11, 0, 0);

        // Randomized accesses
        for (int t = 0; t < 40; t++) begin
            int          kind = $urandom_range(0, 4);
            logic [23:0] addr;
            int          hold;
            if (kind <= 1) addr = {5'd0, 19'($urandom)};
            else if (kind <= 3) addr = {5'd1, 19'($urandom)};
            else addr = {5'($urandom_range(2, 31)), 19'($urandom)};
            hold = (kind == 4 && $urandom_range(0, 1) == 1) ? BT + $urandom_range(0, 4)
                                                             : $urandom_range(1, 10);
            do_access("random", addr, 1'($urandom), hold, -1, 2'b00, 1, 1'($urandom));
            idle_edges($urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
